// File: rtl/icache_pkg.sv
// Shared types and constants for the I-cache refill path and the stall controller.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package icache_pkg;

    // Refill controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_TAG  = 2'd3
    } state_e;

    // Stall request encoding understood by the pipeline stall controller
    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Byte offset width within a line: 16-byte quadword beats, BEATS per line
    function automatic int off_w(input int beats);
        return 4 + $clog2(beats);
    endfunction

    // Tag width: whatever remains above the index and line offset
    function automatic int tag_w(input int addr_w, input int index_w, input int beats);
        return addr_w - index_w - off_w(beats);
    endfunction

endpackage

// File: rtl/icache_beat_cnt.sv
// Beat counter for one side of a refill burst (requests or responses), with beat-order mapping.
// Latency: count updates one cycle after inc_i; last_o and beat_o are combinational from the count.
// Backpressure: none; the owner only raises inc_i when a beat is actually accepted.
module icache_beat_cnt #(
    parameter  int BEATS = 4,
    localparam int BW    = $clog2(BEATS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [BW-1:0] start_i,
    output logic          last_o,
    output logic [BW-1:0] beat_o
);

    localparam logic [BW:0] LAST_CNT = (BW+1)'(BEATS - 1);

    logic [BW:0] cnt_q, cnt_d;

    // Next count: clear dominates increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The next accepted beat completes the line
    assign last_o = (cnt_q == LAST_CNT);

`ifdef ICACHE_CWF_EN
    // Critical word first: start at the missed quadword and wrap around the line
    assign beat_o = start_i + cnt_q[BW-1:0];
`else
    // Linear order from beat 0; the start beat is irrelevant here
    logic [BW-1:0] unused_start;
    assign unused_start = start_i;
    assign beat_o       = cnt_q[BW-1:0];
`endif

endmodule

// File: rtl/icache_refill.sv
// I-cache miss refill: bursts one line from local store into the data RAM, then writes the tag.
// Latency: best case stall high for BEATS+3 cycles (accept, BEATS grants, last write, tag write).
// Backpressure: ls_req/ls_addr hold until ls_gnt; responses accepted whenever ls_rvalid. Option: ICACHE_CWF_EN.
module icache_refill
    import icache_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int BEATS   = 4,
    parameter int INDEX_W = 6
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    miss,
    input  logic [ADDR_W-1:0]                       miss_addr,
    input  logic                                    flush,
    output logic                                    ls_req,
    output logic [ADDR_W-1:0]                       ls_addr,
    input  logic                                    ls_gnt,
    input  logic                                    ls_rvalid,
    input  logic [DATA_W-1:0]                       ls_rdata,
    output logic                                    ram_we,
    output logic [INDEX_W-1:0]                      ram_index,
    output logic [$clog2(BEATS)-1:0]                ram_beat,
    output logic [DATA_W-1:0]                       ram_wdata,
    output logic                                    tag_we,
    output logic [INDEX_W-1:0]                      tag_index,
    output logic [tag_w(ADDR_W, INDEX_W, BEATS)-1:0] tag,
    output logic                                    tag_valid,
    output logic                                    stallreq_fr_cache
);

    localparam int OFF_W = off_w(BEATS);
    localparam int TAG_W = tag_w(ADDR_W, INDEX_W, BEATS);
    localparam int BW    = $clog2(BEATS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              discard_q, discard_d;

    logic          cnt_clr;
    logic          req_inc, rsp_inc;
    logic          req_last, rsp_last;
    logic [BW-1:0] req_beat, rsp_beat;
    logic [BW-1:0] start_beat;

    // Byte offset inside the missed quadword never leaves the block
    logic [3:0] unused_addr_lo;
    assign unused_addr_lo = addr_q[3:0];

    assign start_beat = addr_q[OFF_W-1:4];
    assign cnt_clr    = (state_q == ST_IDLE);
    assign req_inc    = (state_q == ST_REQ) && ls_gnt;
    assign rsp_inc    = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && ls_rvalid;

    icache_beat_cnt #(.BEATS(BEATS)) u_req_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .inc_i   (req_inc),
        .start_i (start_beat),
        .last_o  (req_last),
        .beat_o  (req_beat)
    );

    icache_beat_cnt #(.BEATS(BEATS)) u_rsp_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .inc_i   (rsp_inc),
        .start_i (start_beat),
        .last_o  (rsp_last),
        .beat_o  (rsp_beat)
    );

    // Data goes to the RAM untouched; ram_we qualifies it
    assign ram_wdata = ls_rdata;

    // Next state, latched address, discard flag and all control outputs
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        discard_d         = discard_q;
        ls_req            = 1'b0;
        ls_addr           = '0;
        ram_we            = 1'b0;
        ram_index         = '0;
        ram_beat          = '0;
        tag_we            = 1'b0;
        tag_index         = '0;
        tag               = '0;
        tag_valid         = 1'b0;
        stallreq_fr_cache = NOSTOP;

        unique case (state_q)
            ST_IDLE: begin
                discard_d = 1'b0;
                // A redirect in the same cycle means the miss is already stale
                if (miss && !flush) begin
                    addr_d            = miss_addr;
                    state_d           = ST_REQ;
                    stallreq_fr_cache = STOP;
                end
            end
            ST_REQ: begin
                ls_req  = 1'b1;
                ls_addr = {addr_q[ADDR_W-1:OFF_W], req_beat, 4'b0000};
                if (ls_gnt && req_last) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = ST_WAIT;
            end
            ST_TAG: begin
                tag_we    = 1'b1;
                tag_index = addr_q[OFF_W +: INDEX_W];
                tag       = addr_q[ADDR_W-1 -: TAG_W];
                tag_valid = !discard_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Responses return in order, so the last one always follows the last grant
        if (rsp_inc) begin
            ram_we    = 1'b1;
            ram_index = addr_q[OFF_W +: INDEX_W];
            ram_beat  = rsp_beat;
            if (rsp_last) begin
                state_d = ST_TAG;
            end
        end

        // Finish the burst even after a redirect, but remember to write the tag invalid
        if (state_q != ST_IDLE) begin
            stallreq_fr_cache = STOP;
            if (flush) begin
                discard_d = 1'b1;
            end
        end
    end

    // State, latched miss address and discard flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: table of refill scenarios plus reset and redirect sequences.
// Latency: checks best-case tag write BEATS+2 cycles after the miss is accepted.
// Backpressure: models grant stalls and response gaps from a local-store responder.
module tb_icache_refill;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 128;
    localparam int BEATS   = 4;
    localparam int INDEX_W = 6;
    localparam int OFF_W   = 6;
    localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W;
`ifdef ICACHE_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                miss;
    logic [ADDR_W-1:0]   miss_addr;
    logic                flush;
    logic                ls_req;
    logic [ADDR_W-1:0]   ls_addr;
    logic                ls_gnt;
    logic                ls_rvalid;
    logic [DATA_W-1:0]   ls_rdata;
    logic                ram_we;
    logic [INDEX_W-1:0]  ram_index;
    logic [1:0]          ram_beat;
    logic [DATA_W-1:0]   ram_wdata;
    logic                tag_we;
    logic [INDEX_W-1:0]  tag_index;
    logic [TAG_W-1:0]    tag;
    logic                tag_valid;
    logic                stallreq_fr_cache;

    int n_tests = 0;
    int n_fail  = 0;

    icache_refill #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BEATS  (BEATS),
        .INDEX_W(INDEX_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .miss             (miss),
        .miss_addr        (miss_addr),
        .flush            (flush),
        .ls_req           (ls_req),
        .ls_addr          (ls_addr),
        .ls_gnt           (ls_gnt),
        .ls_rvalid        (ls_rvalid),
        .ls_rdata         (ls_rdata),
        .ram_we           (ram_we),
        .ram_index        (ram_index),
        .ram_beat         (ram_beat),
        .ram_wdata        (ram_wdata),
        .tag_we           (tag_we),
        .tag_index        (tag_index),
        .tag              (tag),
        .tag_valid        (tag_valid),
        .stallreq_fr_cache(stallreq_fr_cache)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          stall_beat;   // request number whose grant is withheld
        int          stall_len;    // cycles the grant is withheld
        int          gap;          // minimum spacing between responses
        int          flush_cyc;    // refill cycle carrying a flush pulse (0 = none)
        logic        exp_valid;
        int          exp_tag_cyc;  // expected tag-write cycle (0 = not checked)
    } case_t;

    typedef struct {
        int          due;
        logic [127:0] data;
    } rsp_t;

    typedef struct {
        logic [5:0]   idx;
        logic [1:0]   beat;
        logic [127:0] data;
    } exp_t;

    rsp_t  rsp_q[$];
    exp_t  sb_q[$];
    case_t cases[5];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] beat_of(input int start, input int g);
        if (CWF) return 2'((start + g) % BEATS);
        return 2'(g);
    endfunction

    task automatic idle_inputs();
        miss      = 1'b0;
        flush     = 1'b0;
        ls_gnt    = 1'b0;
        ls_rvalid = 1'b0;
        ls_rdata  = '0;
    endtask

    task automatic run_case(input case_t tc, input int ci);
        int          g          = 0;
        int          stall_left = tc.stall_len;
        int          writes     = 0;
        int          last_wr    = -100;
        int          last_due   = -100;
        int          due;
        bit          tag_seen   = 1'b0;
        logic [31:0] base       = tc.addr & ~32'h3F;
        int          start      = int'((tc.addr >> 4) & 32'h3);
        logic [5:0]  exp_idx    = 6'((tc.addr >> 6) & 32'h3F);
        logic [31:0] exp_a;
        exp_t        e;
        rsp_t        r;
        rsp_q.delete();
        sb_q.delete();
        for (int c = 0; c < 100 && !tag_seen; c++) begin
            @(posedge clk); #1;
            miss      = 1'b1;
            miss_addr = tc.addr;
            flush     = (tc.flush_cyc != 0) && (c == tc.flush_cyc);
            ls_gnt    = 1'b1;
            if (g == tc.stall_beat && stall_left > 0) begin
                ls_gnt = 1'b0;
                stall_left--;
            end
            ls_rvalid = 1'b0;
            ls_rdata  = '0;
            if (rsp_q.size() > 0 && rsp_q[0].due == c) begin
                r         = rsp_q.pop_front();
                ls_rvalid = 1'b1;
                ls_rdata  = r.data;
            end
            @(negedge clk);
            chk("stall_during_refill", stallreq_fr_cache, 1);
            if (g >= BEATS) begin
                chk("req_after_burst", ls_req, 0);
            end else if (ls_req) begin
                exp_a = base | (32'(beat_of(start, g)) << 4);
                chk("ls_addr", ls_addr, exp_a);
                if (ls_gnt) begin
                    e.idx  = exp_idx;
                    e.beat = beat_of(start, g);
                    e.data = {exp_a, ~exp_a, exp_a ^ 32'h5A5A_A5A5, 32'(ci)};
                    sb_q.push_back(e);
                    due = (c + 1 > last_due + tc.gap) ? c + 1 : last_due + tc.gap;
                    last_due = due;
                    r.due  = due;
                    r.data = e.data;
                    rsp_q.push_back(r);
                    g++;
                end
            end
            if (ram_we) begin
                if (sb_q.size() == 0) begin
                    chk("ram_we_unexpected", ram_we, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ram_index", ram_index, e.idx);
                    chk("ram_beat", ram_beat, e.beat);
                    chk("ram_wdata", ram_wdata, e.data);
                    writes++;
                    last_wr = c;
                end
            end
            if (tag_we) begin
                tag_seen = 1'b1;
                chk("tag", tag, tc.addr >> 12);
                chk("tag_index", tag_index, exp_idx);
                chk("tag_valid", tag_valid, tc.exp_valid);
                chk("writes_before_tag", writes, BEATS);
                chk("tag_after_last_write", c, last_wr + 1);
                if (tc.exp_tag_cyc != 0) chk("tag_cycle", c, tc.exp_tag_cyc);
            end
        end
        if (!tag_seen) chk("tag_timeout", tag_seen, 1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("stall_after_tag", stallreq_fr_cache, 0);
        chk("ram_we_after_tag", ram_we, 0);
        chk("req_after_tag", ls_req, 0);
    endtask

    function automatic logic [127:0] ctrl_outs();
        return 128'({ls_req, ls_addr, ram_we, ram_index, ram_beat, tag_we,
                     tag_index, tag, tag_valid, stallreq_fr_cache});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cases[0] = '{32'h0000_1230, 9, 0, 1, 0, 1'b1, BEATS + 2};
        cases[1] = '{32'hABCD_E7C0, 9, 0, 1, 0, 1'b1, BEATS + 2};
        cases[2] = '{32'h0000_1230, 1, 2, 3, 0, 1'b1, 0};
        cases[3] = '{32'h2000_0050, 9, 0, 1, 5, 1'b0, BEATS + 2};
        cases[4] = '{32'hFFFF_FFF0, 3, 1, 2, 2, 1'b0, 0};

        // Reset state
        idle_inputs();
        miss_addr = '0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        ls_rdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        @(negedge clk);
        chk("reset_outputs", ctrl_outs(), 0);
        chk("reset_wdata_passthru", ram_wdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);

        // Table of refill scenarios
        for (int i = 0; i < 5; i++) begin
            run_case(cases[i], i);
        end

        // Redirect together with a miss in IDLE: no stall, no request
        @(posedge clk); #1;
        idle_inputs();
        miss      = 1'b1;
        flush     = 1'b1;
        ls_gnt    = 1'b1;
        miss_addr = 32'h0000_1230;
        @(negedge clk);
        chk("flush_miss_stall", stallreq_fr_cache, 0);
        chk("flush_miss_req", ls_req, 0);
        @(posedge clk); #1;
        miss  = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_miss_stays_idle", ctrl_outs(), 0);

        // Reset after two grants
        @(posedge clk); #1;
        idle_inputs();
        miss      = 1'b1;
        miss_addr = 32'h0000_3450;
        ls_gnt    = 1'b1;
        @(negedge clk);
        chk("rst_seq_stall", stallreq_fr_cache, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_seq_grant0", ls_req, 1);
        @(posedge clk); #1;
        ls_rvalid = 1'b1;
        @(negedge clk);
        chk("rst_seq_grant1", ls_req, 1);
        @(posedge clk); #1;
        rst    = 1'b1;
        miss   = 1'b0;
        ls_gnt = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", ctrl_outs(), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stray_rvalid_no_we", ram_we, 0);
        chk("stray_rvalid_no_tag", tag_we, 0);
        @(posedge clk); #1;
        ls_rvalid = 1'b0;
        run_case(cases[0], 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
